// File: rtl/hazard_pkg.sv
// Shared encodings for the ID/EX hazard and forwarding controller:
// operand forwarding selects, FSM state encoding and a select-priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_t;

  // The youngest producer (the instruction now in EX) always wins over the older one in MEM.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_EXMEM;
    end else if (mem_hit) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_calc.sv
// Forwarding select for a single ALU operand, computed in ID from the
// destinations currently held in ID/EX and EX/MEM.
module fwd_sel_calc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_dst,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_dst,
  output logic [1:0]            sel
);

  logic ex_hit;
  logic mem_hit;

  // $0 is hardwired to zero, so a write to it must never be forwarded.
  assign ex_hit  = idex_reg_write && (idex_dst != '0) && use_src && (src == idex_dst);
  assign mem_hit = exmem_reg_write && (exmem_dst != '0) && use_src && (src == exmem_dst);

  assign sel = fwd_pick(ex_hit, mem_hit);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID/EX back-channel controller: load-use stall, taken-branch flush, memory-wait freeze
// and registered operand forwarding selects. Define HAZ_PERF_CNT_EN to build the counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_dst,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_dst,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  br_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  flush,
  output logic                  freeze,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic load_use;
  logic freeze_req;

  assign load_use = idex_mem_read && (idex_dst != '0) &&
                    ((id_use_rs && (id_rs == idex_dst)) ||
                     (id_use_rt && (id_rt == idex_dst)));

  assign freeze_req = mem_req && !mem_ready;

  // Pipeline controls: freeze beats a taken branch, which beats a load-use stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (freeze_req) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (br_taken) begin
      flush       = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Forwarding selects for rs (index 0) and rt (index 1).
  logic [REG_ADDR_W-1:0] src_arr [2];
  logic [1:0]            use_vec;
  logic [1:0]            sel_arr [2];

  assign src_arr[0] = id_rs;
  assign src_arr[1] = id_rt;
  assign use_vec    = {id_use_rt, id_use_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel_calc #(
        .REG_ADDR_W(REG_ADDR_W)
      ) u_calc (
        .src            (src_arr[gi]),
        .use_src        (use_vec[gi]),
        .idex_reg_write (idex_reg_write),
        .idex_dst       (idex_dst),
        .exmem_reg_write(exmem_reg_write),
        .exmem_dst      (exmem_dst),
        .sel            (sel_arr[gi])
      );
    end
  endgenerate

  logic [1:0] fwd_a_reg;
  logic [1:0] fwd_b_reg;

  // Selects are computed in ID and clocked into EX alongside the instruction they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (freeze) begin
      fwd_a_reg <= fwd_a_reg;
      fwd_b_reg <= fwd_b_reg;
    end else if (idex_bubble || flush) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else begin
      fwd_a_reg <= sel_arr[0];
      fwd_b_reg <= sel_arr[1];
    end
  end

  assign fwd_a = fwd_a_reg;
  assign fwd_b = fwd_b_reg;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              timeout_reg, timeout_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_next;
    end
  end

  // The wait counter includes the cycle that enters FREEZE, so the timeout
  // flag rises on the MAX_WAIT-th consecutive freeze edge.
  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (freeze_req) begin
          state_next = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (mem_ready) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (state_next == ST_RUN) begin
      wait_next = '0;
    end else if (freeze_req && (wait_reg != WAIT_MAX)) begin
      wait_next = wait_reg + 1'b1;
    end
    if (wait_next == WAIT_MAX) begin
      timeout_next = 1'b1;
    end
  end

  assign mem_timeout = timeout_reg;

`ifdef HAZ_PERF_CNT_EN
  logic             stall_cycle;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic [CNT_W-1:0] freeze_cnt_reg;

  // A load-use cycle only counts as a stall when nothing of higher priority overrides it.
  assign stall_cycle = rst_n && !freeze_req && !br_taken && load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      if (stall_cycle) stall_cnt_reg  <= stall_cnt_reg + 1'b1;
      if (flush)       flush_cnt_reg  <= flush_cnt_reg + 1'b1;
      if (freeze)      freeze_cnt_reg <= freeze_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign flush_cnt  = flush_cnt_reg;
  assign freeze_cnt = freeze_cnt_reg;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl (MAX_WAIT=4); counter expectations follow HAZ_PERF_CNT_EN.
module tb_hazard_fwd_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, idex_dst, exmem_dst;
  logic                  id_use_rs, id_use_rt, idex_mem_read, idex_reg_write;
  logic                  exmem_reg_write, mem_req, mem_ready, br_taken;
  logic                  pc_write, ifid_write, idex_bubble, flush, freeze, mem_timeout;
  logic [1:0]            fwd_a, fwd_b;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt, freeze_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_ADDR_W(REG_ADDR_W),
    .MAX_WAIT  (4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_write (idex_reg_write),
    .idex_dst       (idex_dst),
    .exmem_reg_write(exmem_reg_write),
    .exmem_dst      (exmem_dst),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .br_taken       (br_taken),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_bubble    (idex_bubble),
    .flush          (flush),
    .freeze         (freeze),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .freeze_cnt     (freeze_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; idex_dst = '0; exmem_dst = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; idex_mem_read = 1'b0; idex_reg_write = 1'b0;
    exmem_reg_write = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;

    // 1: reset
    tick();
    tick();
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_ifid_write", 32'(ifid_write), 32'd0);
    check("rst_bubble", 32'(idex_bubble), 32'd1);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    check("rst_freeze_cnt", freeze_cnt, 32'd0);
    rst_n = 1'b1;
    #1;
    check("run_pc_write", 32'(pc_write), 32'd1);
    check("run_bubble", 32'(idex_bubble), 32'd0);

    // 2: load-use on rs, then the load moves to EX/MEM and forwards from MEM/WB
    tick();
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd5;
    id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_ifid_write", 32'(ifid_write), 32'd0);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    check("lu_flush", 32'(flush), 32'd0);
    tick();
    check("lu_fwd_a", 32'(fwd_a), 32'd0);
    check("lu_stall_cnt", stall_cnt, 32'(PERF));
    idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_dst = 5'd0;
    exmem_reg_write = 1'b1; exmem_dst = 5'd5;
    #1;
    check("lu2_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("memwb_fwd_a", 32'(fwd_a), 32'd1);
    check("memwb_fwd_b", 32'(fwd_b), 32'd0);

    // 3: rt matches both producers -> EX/MEM wins; then only MEM/WB; then unused
    id_rs = 5'd0; id_use_rs = 1'b0;
    idex_reg_write = 1'b1; idex_dst = 5'd8; exmem_reg_write = 1'b1; exmem_dst = 5'd8;
    id_rt = 5'd8; id_use_rt = 1'b1;
    tick();
    check("both_fwd_b", 32'(fwd_b), 32'd2);
    check("both_fwd_a", 32'(fwd_a), 32'd0);
    idex_dst = 5'd9;
    tick();
    check("memonly_fwd_b", 32'(fwd_b), 32'd1);
    id_use_rt = 1'b0;
    tick();
    check("unused_fwd_b", 32'(fwd_b), 32'd0);

    // 4: load to $0 never stalls and $0 is never forwarded
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd0;
    exmem_reg_write = 1'b1; exmem_dst = 5'd0;
    id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    check("r0_pc_write", 32'(pc_write), 32'd1);
    check("r0_bubble", 32'(idex_bubble), 32'd0);
    tick();
    check("r0_fwd_a", 32'(fwd_a), 32'd0);

    // 5: taken branch overrides a load-use; forwarding select clears
    idex_mem_read = 1'b0; exmem_reg_write = 1'b0;
    idex_dst = 5'd3; id_rs = 5'd3;
    tick();
    check("pre_br_fwd_a", 32'(fwd_a), 32'd2);
    idex_mem_read = 1'b1; br_taken = 1'b1;
    #1;
    check("br_flush", 32'(flush), 32'd1);
    check("br_bubble", 32'(idex_bubble), 32'd1);
    check("br_pc_write", 32'(pc_write), 32'd1);
    check("br_ifid_write", 32'(ifid_write), 32'd1);
    tick();
    check("br_fwd_a", 32'(fwd_a), 32'd0);
    check("br_flush_cnt", flush_cnt, 32'(PERF));
    check("br_stall_cnt", stall_cnt, 32'(PERF));

    // 6: memory wait freezes everything, even a taken branch, and times out after 4 edges
    br_taken = 1'b0; idex_mem_read = 1'b0;
    tick();
    check("pre_frz_fwd_a", 32'(fwd_a), 32'd2);
    idex_dst = 5'd7;
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    #1;
    check("frz_freeze", 32'(freeze), 32'd1);
    check("frz_flush", 32'(flush), 32'd0);
    check("frz_bubble", 32'(idex_bubble), 32'd0);
    check("frz_pc_write", 32'(pc_write), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("frz_fwd_a_clk%0d", k), 32'(fwd_a), 32'd2);
      check($sformatf("frz_timeout_clk%0d", k), 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
    end
    check("frz_freeze_cnt", freeze_cnt, 32'(6 * PERF));
    br_taken = 1'b0; mem_ready = 1'b1;
    #1;
    check("rdy_freeze", 32'(freeze), 32'd0);
    tick();
    check("rdy_timeout", 32'(mem_timeout), 32'd1);
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("sticky_timeout", 32'(mem_timeout), 32'd1);

    // reset clears the sticky timeout and counters
    rst_n = 1'b0;
    tick();
    check("rst2_timeout", 32'(mem_timeout), 32'd0);
    check("rst2_freeze_cnt", freeze_cnt, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
